// File: rtl/my_counter_pkg.sv
// Shared types and constants for the dual-implementation ones-counter.
package my_counter_pkg;

    localparam int CNT_W = 2;

    typedef logic [1:0] count_t;

    localparam count_t CNT_ZERO = 2'd0;
    localparam count_t CNT_MAX  = 2'd3;

endpackage

// File: rtl/gate_level_my_counter.sv
// Gate-level ones-counter: two chained XORs for sum, majority via and2/or3 for carry.
module gate_level_my_counter (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic w0,
    output logic w1
);

    logic ab_x;
    logic ab_a;
    logic ac_a;
    logic bc_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (w0, ab_x, c);

    and g_a0 (ab_a, a, b);
    and g_a1 (ac_a, a, c);
    and g_a2 (bc_a, b, c);
    or  g_o0 (w1, ab_a, ac_a, bc_a);

endmodule

// File: rtl/my_counter.sv
// Behavioural three-input ones-counter: {w1, w0} = a + b + c.
module my_counter
    import my_counter_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c,
    output logic w0,
    output logic w1
);

    count_t sum_c;

    // Operands are zero-extended so the add is carried out at count width.
    assign sum_c    = {1'b0, a} + {1'b0, b} + {1'b0, c};
    assign {w1, w0} = sum_c;

endmodule

// File: rtl/my_counter_dual.sv
// Registered 3:2 compressor computed twice (behavioural and gate-level) with
// a per-cycle equivalence flag and a sticky flag held until reset.
module my_counter_dual
    import my_counter_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    output logic             beh_sum,
    output logic             beh_carry,
    output logic             gl_sum,
    output logic             gl_carry,
    output logic [CNT_W-1:0] count,
    output logic             mismatch,
    output logic             mismatch_sticky
);

    logic   beh_w0;
    logic   beh_w1;
    logic   gl_w0;
    logic   gl_w1;

    count_t beh_d;
    count_t beh_q;
    count_t gl_d;
    count_t gl_q;
    logic   mis_d;
    logic   mis_q;
    logic   sticky_d;
    logic   sticky_q;

    my_counter u_beh (
        .a  (a),
        .b  (b),
        .c  (c),
        .w0 (beh_w0),
        .w1 (beh_w1)
    );

    gate_level_my_counter u_gl (
        .a  (a),
        .b  (b),
        .c  (c),
        .w0 (gl_w0),
        .w1 (gl_w1)
    );

    // Compare the combinational results so the flag lines up with the data it judges.
    assign beh_d    = {beh_w1, beh_w0};
    assign gl_d     = {gl_w1, gl_w0};
    assign mis_d    = (beh_d != gl_d);
    assign sticky_d = sticky_q | mis_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beh_q    <= CNT_ZERO;
            gl_q     <= CNT_ZERO;
            mis_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            beh_q    <= beh_d;
            gl_q     <= gl_d;
            mis_q    <= mis_d;
            sticky_q <= sticky_d;
        end
    end

    assign beh_sum         = beh_q[0];
    assign beh_carry       = beh_q[1];
    assign gl_sum          = gl_q[0];
    assign gl_carry        = gl_q[1];
    assign count           = CNT_W'(beh_q);
    assign mismatch        = mis_q;
    assign mismatch_sticky = sticky_q;

endmodule

// File: tb/tb_my_counter_dual.sv
// Directed and random checks of the dual ones-counter against hand-computed counts.
module tb_my_counter_dual;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       b;
    logic       c;
    logic       beh_sum;
    logic       beh_carry;
    logic       gl_sum;
    logic       gl_carry;
    logic [1:0] count;
    logic       mismatch;
    logic       mismatch_sticky;

    int n_checks;
    int n_errors;

    my_counter_dual #(.CNT_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a               (a),
        .b               (b),
        .c               (c),
        .beh_sum         (beh_sum),
        .beh_carry       (beh_carry),
        .gl_sum          (gl_sum),
        .gl_carry        (gl_carry),
        .count           (count),
        .mismatch        (mismatch),
        .mismatch_sticky (mismatch_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge, then let one rising edge capture and settle.
    task automatic step(input logic rst_v, input logic [2:0] abc);
        @(negedge clk);
        rst_n     = rst_v;
        {a, b, c} = abc;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] sweep_exp [9];
    logic [2:0] sweep_in  [9];
    logic [2:0] rnd;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        {a, b, c} = 3'b111;

        sweep_in  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
        sweep_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0};

        step(1'b0, 3'b111);
        step(1'b0, 3'b111);
        check("reset count", int'(count), 0);
        check("reset beh_sum", int'(beh_sum), 0);
        check("reset beh_carry", int'(beh_carry), 0);
        check("reset gl_pair", int'({gl_carry, gl_sum}), 0);
        check("reset mismatch", int'(mismatch), 0);
        check("reset sticky", int'(mismatch_sticky), 0);

        for (int i = 0; i < 9; i++) begin
            step(1'b1, sweep_in[i]);
            check($sformatf("sweep count abc=%03b", sweep_in[i]), int'(count), int'(sweep_exp[i]));
            check($sformatf("sweep gl abc=%03b", sweep_in[i]), int'({gl_carry, gl_sum}), int'(sweep_exp[i]));
            check($sformatf("sweep mismatch abc=%03b", sweep_in[i]), int'(mismatch), 0);
        end

        // Latency: new inputs must not show until the next rising edge.
        step(1'b1, 3'b000);
        @(negedge clk);
        {a, b, c} = 3'b111;
        #1;
        check("latency before edge", int'(count), 0);
        @(posedge clk);
        #1;
        check("latency after edge", int'(count), 3);

        step(1'b1, 3'b110);
        check("pre-reset count", int'(count), 2);
        step(1'b0, 3'b110);
        check("midstream reset count", int'(count), 0);
        check("midstream reset gl", int'({gl_carry, gl_sum}), 0);
        step(1'b1, 3'b110);
        check("post-reset count", int'(count), 2);

        // Break the gate-level carry to exercise both mismatch flags.
        @(negedge clk);
        {a, b, c} = 3'b011;
        force dut.gl_w1 = 1'b0;
        @(posedge clk);
        #1;
        check("inject mismatch", int'(mismatch), 1);
        check("inject sticky", int'(mismatch_sticky), 1);
        check("inject gl_carry", int'(gl_carry), 0);
        check("inject count", int'(count), 2);
        @(negedge clk);
        release dut.gl_w1;
        @(posedge clk);
        #1;
        check("release mismatch", int'(mismatch), 0);
        check("release sticky held", int'(mismatch_sticky), 1);
        step(1'b1, 3'b101);
        check("sticky still held", int'(mismatch_sticky), 1);
        step(1'b0, 3'b101);
        check("sticky cleared by reset", int'(mismatch_sticky), 0);

        for (int i = 0; i < 1000; i++) begin
            rnd = 3'($urandom_range(0, 7));
            step(1'b1, rnd);
            check($sformatf("random count abc=%03b", rnd), int'(count), $countones(rnd));
            check("random sticky", int'(mismatch_sticky), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/my_counter_dual.md
# my_counter_dual

Registered three-input ones-counter (3:2 compressor). It computes the population count of inputs `a`, `b` and `c` in two independent ways:

- a behavioural adder, `my_counter`;
- a primitive-gate netlist, `gate_level_my_counter`.

Both 2-bit results are registered and compared every cycle, with an instantaneous and a sticky mismatch flag. It sits in the datapath as a self-checking full-adder cell and as a reference for gate-level equivalence.

## Interface
Parameters:
- `CNT_W`, default 2: count width (fixed; 3 ones needs 2 bits).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `a`  in  1  operand bit 0.
- `b`  in  1  operand bit 1.
- `c`  in  1  operand bit 2.
- `beh_sum`  out  1  registered sum bit (LSB) from `my_counter`.
- `beh_carry`  out  1  registered carry bit (MSB) from `my_counter`.
- `gl_sum`  out  1  registered sum bit from `gate_level_my_counter`.
- `gl_carry`  out  1  registered carry bit from `gate_level_my_counter`.
- `count`  out  2  `{beh_carry, beh_sum}`, the number of ones in a, b, c (0..3).
- `mismatch`  out  1  registered: behavioural and gate-level pairs differ.
- `mismatch_sticky`  out  1  set on any mismatch; cleared only by reset.

## Operation
- Sum = a ^ b ^ c. Carry = majority(a, b, c) = ab | ac | bc.
- Resulting 2-bit count per input pattern abc:
  - 000 → 0
  - 001, 010, 100 → 1
  - 011, 101, 110 → 2
  - 111 → 3
- Sub-module port order is (a, b, c, w0, w1), with w0 = sum and w1 = carry.
- `my_counter`: behavioural; `{w1, w0} = a + b + c`, zero-extended to 2 bits, no overflow possible.
- `gate_level_my_counter`: built only from primitive gates:
  - two-level xor for w0;
  - three and2 into one or3 for w1.
- `mismatch` next value = `{beh}` != `{gl}`, taken from the combinational sub-module outputs in the same cycle.
- `mismatch_sticky` next value = `mismatch_sticky | mismatch_next`.
- No handshake: a new sample is accepted every cycle.

## Timing
- Latency 1 cycle: inputs present before rising edge N appear on all outputs after edge N.
- Throughput 1 sample per cycle.
- Reset:
  - When `rst_n` = 0 at a rising edge, every output register becomes 0, including `count` = 0 and `mismatch_sticky` = 0.
  - Reset has priority over sampling.
- Reset released at edge N (`rst_n` = 1 sampled): the inputs at edge N are captured, so outputs are valid after edge N.
- Reset asserted mid-stream: the outputs held before that edge are discarded and zeros appear after the edge. No partial state survives.
- Asynchronous input changes between edges have no effect on outputs.
- There are no wrap-around or full/empty conditions; all 8 input patterns are legal.

## Structure
- Shared package `my_counter_pkg`: `CNT_W = 2`; `typedef logic [1:0] count_t`; constants `CNT_ZERO = 2'd0`, `CNT_MAX = 2'd3`.
- Sub-modules `my_counter` and `gate_level_my_counter`, each purely combinational with no clock. The top holds all registers and the compare logic.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with abc = 111 → all outputs 0, `mismatch_sticky` = 0.
- Exhaustive sweep: apply abc = 000, 001, 010, 011, 100, 101, 110, 111, then 000, one per cycle. After each edge, `count` must read 0, 1, 1, 2, 1, 2, 2, 3, 0; gl pair = beh pair; `mismatch` = 0.
- Latency: change abc from 000 to 111 just before edge N → `count` = 3 only after edge N, and still 0 before it.
- Mid-stream reset: during the sweep with abc = 110 (expected 2), assert `rst_n` for one edge → `count` = 0. On the next edge with abc = 110 → `count` = 2.
- Mismatch injection: force the `gate_level_my_counter` w1 to 0 with abc = 011 → after the edge, `mismatch` = 1 and `mismatch_sticky` = 1. Release the force → `mismatch` = 0 and `mismatch_sticky` stays 1 until `rst_n` = 0.
- Randomized: 1000 random abc vectors → `count` equals the popcount of the previous cycle's inputs, and `mismatch_sticky` never sets.
